// File: rtl/sramlike_wbuf_bridge_pkg.sv
// Shared types for the sram-like bridge: bus FSM states, size codes and the
// byte-enable to bus size/low-address mapping.
package sramlike_wbuf_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ADDR = 3'd1,
        S_W_DATA = 3'd2,
        S_R_ADDR = 3'd3,
        S_R_DATA = 3'd4
    } bus_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] lo;
    } size_lo_t;

    // Irregular enable patterns fall back to a full word at the CPU address.
    function automatic size_lo_t wen2size(input logic [3:0] wen, input logic [1:0] a);
        size_lo_t r;
        r.size = SZ_WORD;
        r.lo   = a;
        case (wen)
            4'b0011: begin r.size = SZ_HALF; r.lo = 2'b00; end
            4'b1100: begin r.size = SZ_HALF; r.lo = 2'b10; end
            4'b0001: begin r.size = SZ_BYTE; r.lo = 2'b00; end
            4'b0010: begin r.size = SZ_BYTE; r.lo = 2'b01; end
            4'b0100: begin r.size = SZ_BYTE; r.lo = 2'b10; end
            4'b1000: begin r.size = SZ_BYTE; r.lo = 2'b11; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sramlike_wbuf_bridge_wbuf_fifo.sv
// Synchronous FIFO holding posted writes; pointers wrap modulo DEPTH (power of two).
module sramlike_wbuf_bridge_wbuf_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign head  = r_mem[r_rptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/sramlike_wbuf_bridge.sv
// CPU sram-style port to sram-like bus bridge with optional posted-write buffer
// and a global-stall hold so a finished access is never reissued.
module sramlike_wbuf_bridge
    import sramlike_wbuf_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int WBUF_EN    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                longest_stall,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    output logic                wbuf_empty
);

    localparam int ENT_W = ADDR_W + 2 + DATA_W;
    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    bus_state_e r_state, w_state_nx;

    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_is_wr;
    size_lo_t          w_map;
    logic [ADDR_W-1:0] w_cpu_baddr;
    logic [1:0]        w_cpu_size;
    logic              w_pend_rd;
    logic              w_pend_uwr;
    logic              w_push;
    logic              w_rd_done;
    logic              w_uwr_done;
    logic              w_accept;

    logic [ENT_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_hd_addr;
    logic [1:0]        w_hd_size;
    logic [DATA_W-1:0] w_hd_wdata;

    logic              w_load;
    logic              w_ld_wr;
    logic [1:0]        w_ld_size;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [DATA_W-1:0] w_ld_wdata;

    assign w_is_wr     = |cpu_wen;
    assign w_map       = wen2size(cpu_wen, cpu_addr[1:0]);
    assign w_cpu_baddr = w_is_wr ? {cpu_addr[ADDR_W-1:2], w_map.lo} : cpu_addr;
    assign w_cpu_size  = w_is_wr ? w_map.size : SZ_WORD;

    // r_done masks the request the CPU keeps presenting while the pipeline is frozen.
    assign w_pend_rd  = cpu_en & ~w_is_wr & ~r_done;
    assign w_pend_uwr = (WBUF_EN == 0) & cpu_en & w_is_wr & ~r_done;
    assign w_push     = (WBUF_EN != 0) & cpu_en & w_is_wr & ~w_full & ~r_done;
    assign w_rd_done  = (r_state == S_R_DATA) & data_ok;
    assign w_uwr_done = (WBUF_EN == 0) & (r_state == S_W_DATA) & data_ok;
    assign w_accept   = w_push | w_rd_done | w_uwr_done;

    generate
        if (WBUF_EN != 0) begin : g_wbuf
            sramlike_wbuf_bridge_wbuf_fifo #(
                .W     (ENT_W),
                .DEPTH (WBUF_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push),
                .pop   ((r_state == S_W_DATA) & data_ok),
                .din   ({w_cpu_baddr, w_cpu_size, cpu_wdata}),
                .head  (w_head),
                .full  (w_full),
                .empty (w_empty),
                .count (w_count)
            );
        end else begin : g_nowbuf
            assign w_head  = '0;
            assign w_full  = 1'b0;
            assign w_empty = 1'b1;
            assign w_count = '0;
        end
    endgenerate

    assign {w_hd_addr, w_hd_size, w_hd_wdata} = w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    // Buffered writes always win over a new access so reads never pass older writes.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_ld_wr    = 1'b1;
        w_ld_size  = w_hd_size;
        w_ld_addr  = w_hd_addr;
        w_ld_wdata = w_hd_wdata;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nx = S_W_ADDR;
                    w_load     = 1'b1;
                end else if (w_pend_rd) begin
                    w_state_nx = S_R_ADDR;
                    w_load     = 1'b1;
                    w_ld_wr    = 1'b0;
                    w_ld_size  = SZ_WORD;
                    w_ld_addr  = cpu_addr;
                    w_ld_wdata = cpu_wdata;
                end else if (w_pend_uwr) begin
                    w_state_nx = S_W_ADDR;
                    w_load     = 1'b1;
                    w_ld_size  = w_cpu_size;
                    w_ld_addr  = w_cpu_baddr;
                    w_ld_wdata = cpu_wdata;
                end
            end
            S_W_ADDR: if (addr_ok) w_state_nx = S_W_DATA;
            S_W_DATA: if (data_ok) w_state_nx = S_IDLE;
            S_R_ADDR: if (addr_ok) w_state_nx = S_R_DATA;
            S_R_DATA: if (data_ok) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_wr    <= w_ld_wr;
            r_size  <= w_ld_size;
            r_addr  <= w_ld_addr;
            r_wdata <= w_ld_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               r_done <= 1'b0;
        else if (!longest_stall) r_done <= 1'b0;
        else if (w_accept)      r_done <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_rdata <= '0;
        else if (w_rd_done) r_rdata <= rdata;
    end

    assign req        = (r_state == S_W_ADDR) | (r_state == S_R_ADDR);
    assign wr         = r_wr;
    assign size       = r_size;
    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign cpu_rdata  = w_rd_done ? rdata : r_rdata;
    assign cpu_stall  = cpu_en & ~r_done & ~w_accept;
    assign wbuf_empty = (w_count == '0);

endmodule

// File: tb/tb_sramlike_wbuf_bridge.sv
// Directed bench for sramlike_wbuf_bridge: size-mapping vector table plus
// hand-timed read, posted-write, ordering, stall-hold and reset sequences.
module tb_sramlike_wbuf_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        longest_stall;
    logic        ext_stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;
    logic        wbuf_empty;

    // Bus slave: addr_ok follows req when enabled, data_ok one cycle after handshake.
    logic        aok_en;
    logic        dok_en;
    logic        r_dp;
    logic [31:0] slv_rdata;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_rec_t;
    bus_rec_t bus_log[$];

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[8];

    int n_chk = 0;
    int n_err = 0;
    int base;
    int nrd;
    logic found;

    sramlike_wbuf_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .WBUF_DEPTH (4),
        .WBUF_EN    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_en        (cpu_en),
        .cpu_wen       (cpu_wen),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .longest_stall (longest_stall),
        .req           (req),
        .wr            (wr),
        .size          (size),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .addr_ok       (addr_ok),
        .data_ok       (data_ok),
        .wbuf_empty    (wbuf_empty)
    );

    always #5 clk = ~clk;

    assign longest_stall = cpu_stall | ext_stall;
    assign addr_ok       = req & aok_en;
    assign data_ok       = r_dp & dok_en;
    assign rdata         = slv_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp <= 1'b0;
        end else begin
            if (data_ok) r_dp <= 1'b0;
            if (req && addr_ok) begin
                r_dp <= 1'b1;
                bus_log.push_back('{wr, size, addr, wdata});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (!(wbuf_empty && !req && !r_dp) && k < 100) begin
            cyc();
            #1;
            k++;
        end
        chk(nm, {31'd0, wbuf_empty && !req && !r_dp}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        ext_stall = 1'b0; aok_en = 1'b1; dok_en = 1'b1; slv_rdata = '0;

        vecs[0] = '{4'b0100, 32'h2003, 32'h0000_0055, 2'd0, 32'h2002};
        vecs[1] = '{4'b1100, 32'h2003, 32'h5566_0000, 2'd1, 32'h2002};
        vecs[2] = '{4'b0011, 32'h2003, 32'h0000_7788, 2'd1, 32'h2000};
        vecs[3] = '{4'b1111, 32'h2003, 32'h1122_3344, 2'd2, 32'h2003};
        vecs[4] = '{4'b0001, 32'h2001, 32'h0000_0099, 2'd0, 32'h2000};
        vecs[5] = '{4'b1000, 32'h2000, 32'hAB00_0000, 2'd0, 32'h2003};
        vecs[6] = '{4'b0101, 32'h2002, 32'h00CD_00EF, 2'd2, 32'h2002};
        vecs[7] = '{4'b0010, 32'h2000, 32'h0000_1200, 2'd0, 32'h2001};

        #2;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_size", {30'd0, size}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_empty", {31'd0, wbuf_empty}, 32'd1);
        chk("rst_rdata", cpu_rdata, 32'd0);
        cyc(); cyc(); rst = 1'b1;

        // zero-wait read
        slv_rdata = 32'hDEADBEEF; base = bus_log.size();
        cyc(); cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h1000; #1;
        chk("rd_c0_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rd_c0_req", {31'd0, req}, 32'd0);
        cyc(); #1;
        chk("rd_c1_req", {31'd0, req}, 32'd1);
        chk("rd_c1_wr", {31'd0, wr}, 32'd0);
        chk("rd_c1_size", {30'd0, size}, 32'd2);
        chk("rd_c1_addr", addr, 32'h1000);
        cyc(); #1;
        chk("rd_c2_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rd_c2_rdata", cpu_rdata, 32'hDEADBEEF);
        cyc(); cpu_en = 1'b0; slv_rdata = 32'h0; #1;
        chk("rd_hold_rdata", cpu_rdata, 32'hDEADBEEF);
        cyc(); #1;
        chk("rd_one_txn", bus_log.size() - base, 32'd1);

        // five posted writes with addr_ok withheld
        aok_en = 1'b0; base = bus_log.size();
        for (int i = 0; i < 4; i++) begin
            cyc(); cpu_en = 1'b1; cpu_wen = 4'hF;
            cpu_addr = 32'h3000 + 4 * i; cpu_wdata = 32'hA000_0000 + i; #1;
            chk($sformatf("wr%0d_nostall", i), {31'd0, cpu_stall}, 32'd0);
        end
        cyc(); cpu_addr = 32'h3010; cpu_wdata = 32'hA000_0004; #1;
        chk("wr4_full_stall", {31'd0, cpu_stall}, 32'd1);
        chk("wr4_notempty", {31'd0, wbuf_empty}, 32'd0);
        chk("wr4_req", {31'd0, req}, 32'd1);
        aok_en = 1'b1;
        cyc(); #1;
        chk("wr4_dok", {31'd0, data_ok}, 32'd1);
        chk("wr4_stall_at_pop", {31'd0, cpu_stall}, 32'd1);
        cyc(); #1;
        chk("wr4_accept", {31'd0, cpu_stall}, 32'd0);
        cyc(); cpu_en = 1'b0; cpu_wen = 4'h0;
        wait_drain("wr5_drain");
        chk("wr5_count", bus_log.size() - base, 32'd5);
        if (bus_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("wr_order_addr%0d", i), bus_log[base+i].addr, 32'h3000 + 4 * i);
                chk($sformatf("wr_order_data%0d", i), bus_log[base+i].wdata, 32'hA000_0000 + i);
            end
        end

        // size mapping table
        for (int v = 0; v < 8; v++) begin
            base = bus_log.size();
            cyc(); cpu_en = 1'b1; cpu_wen = vecs[v].wen;
            cpu_addr = vecs[v].a; cpu_wdata = vecs[v].d;
            cyc(); cpu_en = 1'b0; cpu_wen = 4'h0;
            wait_drain($sformatf("map%0d_drain", v));
            chk($sformatf("map%0d_cnt", v), bus_log.size() - base, 32'd1);
            if (bus_log.size() > base) begin
                chk($sformatf("map%0d_size", v), {30'd0, bus_log[base].size}, {30'd0, vecs[v].exp_size});
                chk($sformatf("map%0d_addr", v), bus_log[base].addr, vecs[v].exp_addr);
                chk($sformatf("map%0d_wr", v), {31'd0, bus_log[base].wr}, 32'd1);
            end
        end

        // read behind two buffered writes
        aok_en = 1'b0; base = bus_log.size();
        cyc(); cpu_en = 1'b1; cpu_wen = 4'hF; cpu_addr = 32'h5000; cpu_wdata = 32'h1;
        cyc(); cpu_addr = 32'h5004; cpu_wdata = 32'h2;
        cyc(); cpu_wen = 4'h0; cpu_addr = 32'h5100; slv_rdata = 32'hCAFEF00D; #1;
        chk("rdw_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rdw_notempty", {31'd0, wbuf_empty}, 32'd0);
        aok_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(); #1;
            if (req && !wr) found = 1'b1;
        end
        chk("rdw_req_seen", {31'd0, found}, 32'd1);
        chk("rdw_empty_before_req", {31'd0, wbuf_empty}, 32'd1);
        chk("rdw_two_writes_first", bus_log.size() - base, 32'd2);
        chk("rdw_req_addr", addr, 32'h5100);
        cyc(); #1;
        chk("rdw_done_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rdw_rdata", cpu_rdata, 32'hCAFEF00D);
        cyc(); cpu_en = 1'b0;

        // read finishing under a longer global stall
        cyc(); base = bus_log.size();
        ext_stall = 1'b1; cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h4000;
        slv_rdata = 32'h1234_5678;
        cyc(); #1;
        chk("hold_c1_req", {31'd0, req}, 32'd1);
        cyc(); #1;
        chk("hold_c2_stall", {31'd0, cpu_stall}, 32'd0);
        chk("hold_c2_rdata", cpu_rdata, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            cyc(); slv_rdata = 32'hBAD0_BAD0; #1;
            chk($sformatf("hold%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
            chk($sformatf("hold%0d_rdata", i), cpu_rdata, 32'h1234_5678);
            chk($sformatf("hold%0d_req", i), {31'd0, req}, 32'd0);
        end
        cyc(); ext_stall = 1'b0; #1;
        chk("hold_release_stall", {31'd0, cpu_stall}, 32'd0);
        cyc(); cpu_en = 1'b0;
        cyc(); cyc(); #1;
        nrd = 0;
        for (int i = base; i < bus_log.size(); i++) if (!bus_log[i].wr) nrd++;
        chk("hold_one_read", nrd, 32'd1);

        // reset during a write data phase with three entries buffered
        aok_en = 1'b1; dok_en = 1'b0; base = bus_log.size();
        for (int i = 0; i < 3; i++) begin
            cyc(); cpu_en = 1'b1; cpu_wen = 4'hF; cpu_addr = 32'h6000 + 4 * i; cpu_wdata = 32'h77 + i;
        end
        cyc(); cpu_wen = 4'h0; cpu_addr = 32'h6100; #1;
        chk("rstm_notempty", {31'd0, wbuf_empty}, 32'd0);
        chk("rstm_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rstm_dphase_req", {31'd0, req}, 32'd0);
        cyc(); rst = 1'b0; cpu_en = 1'b0; #1;
        chk("rstm_req", {31'd0, req}, 32'd0);
        chk("rstm_empty", {31'd0, wbuf_empty}, 32'd1);
        chk("rstm_stall0", {31'd0, cpu_stall}, 32'd0);
        chk("rstm_addr", addr, 32'd0);
        cyc(); #1;
        chk("rstm_next_req", {31'd0, req}, 32'd0);
        chk("rstm_next_empty", {31'd0, wbuf_empty}, 32'd1);
        chk("rstm_next_stall", {31'd0, cpu_stall}, 32'd0);
        cyc(); rst = 1'b1; dok_en = 1'b1;
        cyc(); #1;
        chk("rstm_post_req", {31'd0, req}, 32'd0);
        cyc(); #1;
        chk("rstm_post_req2", {31'd0, req}, 32'd0);
        chk("rstm_no_replay", bus_log.size() - base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
